// File: rtl/gear_pkg.sv
// Shared gear codes, FSM state type and request-qualification helpers for the
// gear selector and the display unit's gear decode.
package gear_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    typedef enum logic {
        STABLE,
        SHIFTING
    } state_t;

    function automatic logic is_gear_key(input logic [3:0] code);
        return (code == GEAR_P) || (code == GEAR_R) || (code == GEAR_N) || (code == GEAR_D);
    endfunction

    // Parking-side targets need a stopped, braked vehicle; leaving P always needs brake.
    function automatic logic interlock_ok(input logic [3:0] cur, input logic [3:0] tgt,
                                          input logic [7:0] speed, input logic brake);
        logic ok;
        ok = 1'b1;
        if (((tgt == GEAR_P) || (tgt == GEAR_R)) && !((speed == 8'd0) && brake))
            ok = 1'b0;
        if ((cur == GEAR_P) && !brake)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/gear_shift_ctrl_timer.sv
// Shift delay counter: cleared while idle, counts ticks, saturates at SHIFT_TICKS.
module shift_timer #(
    parameter int SHIFT_TICKS = 300,
    parameter int CNT_W       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic tick_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SHIFT_TICKS);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (tick_i && (count_q != LIMIT))
            count_d = count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign done_o = (count_q == LIMIT);

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear selector FSM: qualifies keypad gear requests against brake/speed interlocks,
// runs a timed shift, and drives the registered gear code and torque enables.
module gear_shift_ctrl
    import gear_pkg::*;
#(
    parameter int SHIFT_TICKS = 300,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       brake,
    input  logic [7:0] speed,
    output logic [3:0] gear_char,
    output logic       shift_busy,
    output logic       shift_reject,
    output logic       drive_en,
    output logic       reverse_en
);

    state_t     state_q;
    logic [3:0] gear_q;
    logic [3:0] target_q;
    logic       busy_q;
    logic       reject_q;
    logic       drive_q;
    logic       reverse_q;
    logic       timer_done;

    shift_timer #(
        .SHIFT_TICKS(SHIFT_TICKS),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == STABLE),
        .tick_i(tick_ms),
        .done_o(timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STABLE;
            gear_q    <= GEAR_P;
            target_q  <= GEAR_P;
            busy_q    <= 1'b0;
            reject_q  <= 1'b0;
            drive_q   <= 1'b0;
            reverse_q <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (key_valid && is_gear_key(key_code) && (key_code != gear_q)) begin
                        if (interlock_ok(gear_q, key_code, speed, brake)) begin
                            target_q  <= key_code;
                            state_q   <= SHIFTING;
                            busy_q    <= 1'b1;
                            drive_q   <= 1'b0;
                            reverse_q <= 1'b0;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                SHIFTING: begin
                    if (key_valid && is_gear_key(key_code))
                        reject_q <= 1'b1;
                    // Rolling vehicle while heading for P/R: fall back to neutral, abort wins.
                    if (((target_q == GEAR_P) || (target_q == GEAR_R)) && (speed != 8'd0)) begin
                        gear_q   <= GEAR_N;
                        state_q  <= STABLE;
                        busy_q   <= 1'b0;
                        reject_q <= 1'b1;
                    end else if (timer_done) begin
                        gear_q    <= target_q;
                        state_q   <= STABLE;
                        busy_q    <= 1'b0;
                        drive_q   <= (target_q == GEAR_D);
                        reverse_q <= (target_q == GEAR_R);
                    end
                end
                default: state_q <= STABLE;
            endcase
        end
    end

    assign gear_char    = gear_q;
    assign shift_busy   = busy_q;
    assign shift_reject = reject_q;
    assign drive_en     = drive_q;
    assign reverse_en   = reverse_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench for gear_shift_ctrl with a 3-tick shift delay and a tick every 5 cycles.
module tb_gear_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_ms = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       brake = 1'b0;
    logic [7:0] speed = 8'd0;
    logic [3:0] gear_char;
    logic       shift_busy;
    logic       shift_reject;
    logic       drive_en;
    logic       reverse_en;

    int n_vec = 0;
    int n_err = 0;

    gear_shift_ctrl #(
        .SHIFT_TICKS(3),
        .CNT_W      (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_ms     (tick_ms),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .brake       (brake),
        .speed       (speed),
        .gear_char   (gear_char),
        .shift_busy  (shift_busy),
        .shift_reject(shift_reject),
        .drive_en    (drive_en),
        .reverse_en  (reverse_en)
    );

    always #5 clk = ~clk;

    // Packed view: {gear_char, busy, reject, drive_en, reverse_en}
    function automatic logic [7:0] outs();
        return {gear_char, shift_busy, shift_reject, drive_en, reverse_en};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            step(4);
            tick_ms = 1'b1;
            step();
            tick_ms = 1'b0;
        end
    endtask

    task automatic go(input logic [3:0] code);
        press(code);
        do_ticks(3);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        n_vec++;
        if (outs() !== {4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_idle got=%h want=%h", outs(), {4'd3, 4'b0000});
        end
    endtask

    task automatic test_shift_to_d();
        brake = 1'b1;
        speed = 8'd0;
        press(4'd12);
        n_vec++;
        if (outs() !== {4'd3, 4'b1000}) begin
            n_err++;
            $display("FAIL p2d_accept got=%h want=%h", outs(), {4'd3, 4'b1000});
        end
        for (int k = 1; k <= 3; k++) begin
            do_ticks(1);
            n_vec++;
            if (outs() !== {4'd3, 4'b1000}) begin
                n_err++;
                $display("FAIL p2d_busy_tick%0d got=%h want=%h", k, outs(), {4'd3, 4'b1000});
            end
        end
        step();
        n_vec++;
        if (outs() !== {4'd12, 4'b0010}) begin
            n_err++;
            $display("FAIL p2d_done got=%h want=%h", outs(), {4'd12, 4'b0010});
        end
    endtask

    task automatic test_reject_r_at_speed();
        speed = 8'd40;
        brake = 1'b1;
        press(4'd6);
        n_vec++;
        if (outs() !== {4'd12, 4'b0110}) begin
            n_err++;
            $display("FAIL d2r_reject got=%h want=%h", outs(), {4'd12, 4'b0110});
        end
        step();
        n_vec++;
        if (outs() !== {4'd12, 4'b0010}) begin
            n_err++;
            $display("FAIL d2r_pulse_end got=%h want=%h", outs(), {4'd12, 4'b0010});
        end
    endtask

    task automatic test_n_d_no_interlock();
        go(4'd9);
        n_vec++;
        if (outs() !== {4'd9, 4'b0000}) begin
            n_err++;
            $display("FAIL d2n_done got=%h want=%h", outs(), {4'd9, 4'b0000});
        end
        brake = 1'b0;
        press(4'd12);
        n_vec++;
        if (outs() !== {4'd9, 4'b1000}) begin
            n_err++;
            $display("FAIL n2d_accept got=%h want=%h", outs(), {4'd9, 4'b1000});
        end
        do_ticks(3);
        step();
        n_vec++;
        if (outs() !== {4'd12, 4'b0010}) begin
            n_err++;
            $display("FAIL n2d_done got=%h want=%h", outs(), {4'd12, 4'b0010});
        end
    endtask

    task automatic test_p_reject_and_ignore();
        rst = 1'b1;
        step();
        rst = 1'b0;
        speed = 8'd0;
        brake = 1'b0;
        press(4'd9);
        n_vec++;
        if (outs() !== {4'd3, 4'b0100}) begin
            n_err++;
            $display("FAIL p2n_nobrake_reject got=%h want=%h", outs(), {4'd3, 4'b0100});
        end
        step();
        n_vec++;
        if (outs() !== {4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL p2n_pulse_end got=%h want=%h", outs(), {4'd3, 4'b0000});
        end
        brake = 1'b1;
        press(4'd3);
        n_vec++;
        if (outs() !== {4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL same_gear_ignored got=%h want=%h", outs(), {4'd3, 4'b0000});
        end
        press(4'd5);
        n_vec++;
        if (outs() !== {4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL non_gear_ignored got=%h want=%h", outs(), {4'd3, 4'b0000});
        end
    endtask

    task automatic test_reverse();
        brake = 1'b1;
        speed = 8'd0;
        go(4'd6);
        n_vec++;
        if (outs() !== {4'd6, 4'b0001}) begin
            n_err++;
            $display("FAIL p2r_done got=%h want=%h", outs(), {4'd6, 4'b0001});
        end
    endtask

    task automatic test_abort();
        go(4'd9);
        press(4'd3);
        n_vec++;
        if (outs() !== {4'd9, 4'b1000}) begin
            n_err++;
            $display("FAIL n2p_accept got=%h want=%h", outs(), {4'd9, 4'b1000});
        end
        press(4'd6);
        n_vec++;
        if (outs() !== {4'd9, 4'b1100}) begin
            n_err++;
            $display("FAIL busy_key_reject got=%h want=%h", outs(), {4'd9, 4'b1100});
        end
        press(4'd5);
        n_vec++;
        if (outs() !== {4'd9, 4'b1000}) begin
            n_err++;
            $display("FAIL busy_nongear_quiet got=%h want=%h", outs(), {4'd9, 4'b1000});
        end
        speed = 8'd5;
        step();
        n_vec++;
        if (outs() !== {4'd9, 4'b0100}) begin
            n_err++;
            $display("FAIL abort_to_n got=%h want=%h", outs(), {4'd9, 4'b0100});
        end
        step();
        n_vec++;
        if (outs() !== {4'd9, 4'b0000}) begin
            n_err++;
            $display("FAIL abort_pulse_end got=%h want=%h", outs(), {4'd9, 4'b0000});
        end
        speed = 8'd0;
    endtask

    task automatic test_reset_mid_shift();
        brake = 1'b1;
        press(4'd12);
        do_ticks(1);
        rst = 1'b1;
        step();
        n_vec++;
        if (outs() !== {4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL rst_mid_shift got=%h want=%h", outs(), {4'd3, 4'b0000});
        end
        rst = 1'b0;
        do_ticks(4);
        step();
        n_vec++;
        if (outs() !== {4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL rst_no_late_done got=%h want=%h", outs(), {4'd3, 4'b0000});
        end
    endtask

    initial begin
        test_reset();
        test_shift_to_d();
        test_reject_r_at_speed();
        test_n_d_no_interlock();
        test_p_reject_and_ignore();
        test_reverse();
        rst = 1'b1;
        step();
        rst = 1'b0;
        test_abort();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
